fp16_add64_arbiter: RTL and testbench
=====================================

Name: fp16_add64_arbiter

Overview:
- Shares one FP16_add64 reduction tree (64 FP16 lanes in, one FP16 sum out, AXI-stream-style valid/ready on both sides, in-order, variable latency) between NREQ requesters.
- Selects a requester each issue slot by round-robin and drives its 64-lane vector into the tree.
- Records the requester ID in an in-order tag FIFO and routes each tree result back to the requester that issued it.
- Sits between the attention/softmax row engines and the single shared add64 tree instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 16, tag FIFO depth: maximum number of vectors issued to the tree but not yet returned (power of 2).
- TAG_W, $clog2(NREQ), requester-ID width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester vector valid.
- req_ready  out  NREQ  per-requester vector accepted.
- req_data  in  NREQ*1024  requester r's vector at [r*1024 +: 1024], 64 FP16 lanes.
- tree_x  out  1024  vector to tree x input.
- tree_x_valid  out  1  to tree x_valid.
- tree_ready  in  1  from tree sum_ready_all.
- tree_sum  in  16  from tree sum.
- tree_sum_valid  in  1  from tree sum_valid.
- tree_next_ready  out  1  to tree next_ready.
- rsp_sum  out  16  result, broadcast to all requesters.
- rsp_valid  out  NREQ  one-hot result valid.
- rsp_ready  in  NREQ  per-requester result ready.
- inflight  out  $clog2(MAX_INFLIGHT+1)  tag FIFO occupancy.
- err_orphan  out  1  sticky: tree result arrived with empty tag FIFO.

Behaviour:
- Reset (async, active-high): rr_ptr=0, FIFO rd/wr pointers=0, inflight=0, lock=0, err_orphan=0. While rst=1, req_ready, rsp_valid, tree_x_valid and tree_next_ready are forced to 0.
- Eligibility: issue is possible when |req_valid and inflight<MAX_INFLIGHT. tree_x_valid = issue-possible. tree_x_valid never depends on tree_ready.
- Grant selection:
  - Combinational round-robin, searching from rr_ptr upward with wrap.
  - After reset, requester 0 has highest priority.
  - With a single valid requester, that requester is granted every cycle with no bubbles.
- Grant lock:
  - If tree_x_valid=1 and tree_ready=0, set lock and hold the granted ID in a register.
  - While locked, grant, tree_x and tree_x_valid stay stable until the handshake, even if higher-priority requests appear.
  - Requesters must hold req_valid and req_data until req_ready.
- Issue handshake (tree_x_valid & tree_ready):
  - req_ready[g]=1 in the same cycle (req_ready = one-hot grant & tree_ready & tree_x_valid).
  - Push g into the tag FIFO, set rr_ptr=(g+1) mod NREQ, clear lock.
  - Zero added latency: tree_x is a combinational mux of req_data by grant.
- Response routing:
  - head = FIFO head tag.
  - If inflight>0: rsp_valid[head]=tree_sum_valid, other bits 0; tree_next_ready=rsp_ready[head]; rsp_sum=tree_sum.
  - On tree_sum_valid & tree_next_ready, pop the FIFO.
  - Results are in-order, so one head tag suffices.
- Orphan result (tree_sum_valid=1, inflight=0): tree_next_ready=1 (drain), rsp_valid=0, err_orphan is set and stays set until reset.
- Simultaneous push and pop: inflight unchanged, pointers both advance.
- FIFO full: push is blocked by eligibility (tree_x_valid=0) even if a pop occurs in the same cycle. This costs one bubble and removes any ready-path from response to issue.
- Pointers wrap modulo MAX_INFLIGHT. inflight range is 0..MAX_INFLIGHT.
- Reset mid-operation: all in-flight tags are discarded. The system resets the tree concurrently (rst_n = ~rst), so no stale results are expected.

Decomposition:
- Package fp16_add_pkg holds: FP16_W=16, ADD64_LANES=64, VEC_W=ADD64_LANES*FP16_W, the typedef fp16_t, and the function rr_pick(valid, ptr) returning a one-hot grant.
- One sub-module: tag_fifo (sync FIFO, width TAG_W, depth MAX_INFLIGHT, with full/empty/count outputs).
- Round-robin arbitration and lock logic stay inline.

Test Plan:
- Single request: req_valid=0001, lane i=FP16 1.0 (0x3C00), tree model with latency 6, always ready -> req_ready[0] pulses the same cycle; 6 cycles later rsp_valid=0001, rsp_sum=0x5400 (64.0); inflight goes 0->1->0.
- Fairness: all four req_valid held high for 8 handshakes -> grant order 0,1,2,3,0,1,2,3; each requester receives exactly 2 responses, in issue order.
- Issue backpressure: tree_ready=0 for 5 cycles with req 2 granted; req 0 is raised mid-stall -> tree_x stays equal to req 2's data and grant stays 2; when tree_ready=1 the handshake goes to req 2, then to req 0 next.
- Full FIFO: tree model holds results (next_ready withheld) and req 1 issues 16 vectors -> inflight=16 and tree_x_valid=0; after one pop, tree_x_valid returns to 1 the following cycle.
- Response backpressure: rsp_ready[3]=0 for 4 cycles while the result for req 3 is pending -> tree_next_ready=0 and rsp_valid=1000 held with stable rsp_sum; pop occurs on the cycle rsp_ready[3]=1.
- Orphan and reset: inject tree_sum_valid with inflight=0 -> err_orphan=1 and stays set. Later assert rst with inflight=5 -> inflight=0, err_orphan=0, all valids low; the first post-reset grant goes to req 0.

Source files
------------

// File: rtl/fp16_add_pkg.sv
// rtl/fp16_add_pkg.sv - shared FP16 vector widths and round-robin pick helper
package fp16_add_pkg;

   localparam int FP16_W      = 16;
   localparam int ADD64_LANES = 64;
   localparam int VEC_W       = ADD64_LANES * FP16_W;
   localparam int RR_MAX      = 8;

   typedef logic [FP16_W-1:0] fp16_t;

   // One-hot grant of the first valid requester at or after ptr, wrapping at n.
   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                 input logic [2:0]        ptr,
                                                 input logic [3:0]        n);
      logic [3:0] idx;
      logic       found;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 0; k < RR_MAX; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= n) idx = idx - n;
         if ((4'(k) < n) && !found && valid[idx[2:0]]) begin
            rr_pick[idx[2:0]] = 1'b1;
            found             = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/fp16_add64_arbiter_tag_fifo.sv
// rtl/fp16_add64_arbiter_tag_fifo.sv - in-order requester-ID FIFO
module tag_fifo #(
   parameter  int W     = 2,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fp16_add64_arbiter.sv
// rtl/fp16_add64_arbiter.sv - round-robin sharing of one add64 reduction tree
// Grants are locked across tree stalls; a tag FIFO routes in-order results home.
module fp16_add64_arbiter
   import fp16_add_pkg::*;
#(
   parameter  int NREQ         = 4,
   parameter  int MAX_INFLIGHT = 16,
   localparam int TAG_W        = $clog2(NREQ),
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*VEC_W-1:0]  req_data,
   output logic [VEC_W-1:0]       tree_x,
   output logic                   tree_x_valid,
   input  logic                   tree_ready,
   input  logic [FP16_W-1:0]      tree_sum,
   input  logic                   tree_sum_valid,
   output logic                   tree_next_ready,
   output logic [FP16_W-1:0]      rsp_sum,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [CNT_W-1:0]       inflight,
   output logic                   err_orphan
);

   logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              lock_q, lock_d;
   logic [TAG_W-1:0]  lock_id_q, lock_id_d;
   logic              err_orphan_q, err_orphan_d;

   logic [RR_MAX-1:0] valid_pad;
   logic [2:0]        ptr_pad;
   logic [RR_MAX-1:0] pick;
   logic [TAG_W-1:0]  pick_id;
   logic [TAG_W-1:0]  grant_id;
   logic [NREQ-1:0]   grant_oh;
   logic [NREQ-1:0]   head_oh;

   logic              fifo_full;
   logic              fifo_empty;
   logic [TAG_W-1:0]  head_tag;
   logic              issue_ok;
   logic              issue_hs;
   logic              pop;
   logic              orphan;

   always_comb begin
      valid_pad            = '0;
      valid_pad[NREQ-1:0]  = req_valid;
      ptr_pad              = '0;
      ptr_pad[TAG_W-1:0]   = rr_ptr_q;
      pick                 = rr_pick(valid_pad, ptr_pad, 4'(NREQ));
      pick_id              = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (pick[r]) pick_id = TAG_W'(r);
      end
      grant_id             = lock_q ? lock_id_q : pick_id;
      grant_oh             = '0;
      grant_oh[grant_id]   = 1'b1;
      head_oh              = '0;
      head_oh[head_tag]    = 1'b1;
   end

   // Full FIFO blocks issue outright, so tree_x_valid never depends on a pop.
   assign issue_ok        = ~rst & (|req_valid) & ~fifo_full;
   assign issue_hs        = issue_ok & tree_ready;
   assign tree_x_valid    = issue_ok;
   assign tree_x          = req_data[int'(grant_id)*VEC_W +: VEC_W];
   assign req_ready       = issue_hs ? grant_oh : '0;

   assign rsp_sum         = tree_sum;
   assign rsp_valid       = (~rst & ~fifo_empty & tree_sum_valid) ? head_oh : '0;
   assign tree_next_ready = ~rst & (fifo_empty | rsp_ready[head_tag]);
   assign pop             = tree_sum_valid & tree_next_ready & ~fifo_empty;
   assign orphan          = tree_sum_valid & fifo_empty;
   assign err_orphan      = err_orphan_q;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
      err_orphan_d = err_orphan_q | orphan;
      if (issue_hs) begin
         rr_ptr_d = (grant_id == TAG_W'(NREQ - 1)) ? '0 : grant_id + TAG_W'(1);
         lock_d   = 1'b0;
      end else if (issue_ok) begin
         lock_d    = 1'b1;
         lock_id_d = grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         lock_q       <= 1'b0;
         lock_id_q    <= '0;
         err_orphan_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_q       <= lock_d;
         lock_id_q    <= lock_id_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   tag_fifo #(
      .W     (TAG_W),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (issue_hs),
      .push_data (grant_id),
      .pop       (pop),
      .pop_data  (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (inflight)
   );

endmodule

// File: tb/tb_fp16_add64_arbiter.sv
// tb/tb_fp16_add64_arbiter.sv - directed bench with tree model and response scoreboard
module tb_fp16_add64_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [4095:0] req_data;
   logic [1023:0] tree_x;
   logic          tree_x_valid;
   logic          tree_ready;
   logic [15:0]   tree_sum;
   logic          tree_sum_valid;
   logic          tree_next_ready;
   logic [15:0]   rsp_sum;
   logic [3:0]    rsp_valid;
   logic [3:0]    rsp_ready;
   logic [4:0]    inflight;
   logic          err_orphan;

   fp16_add64_arbiter #(.NREQ(4), .MAX_INFLIGHT(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .tree_x          (tree_x),
      .tree_x_valid    (tree_x_valid),
      .tree_ready      (tree_ready),
      .tree_sum        (tree_sum),
      .tree_sum_valid  (tree_sum_valid),
      .tree_next_ready (tree_next_ready),
      .rsp_sum         (rsp_sum),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .inflight        (inflight),
      .err_orphan      (err_orphan)
   );

   always #5 clk = ~clk;

   typedef struct { int id; logic [15:0] sum; } sb_t;
   typedef struct { logic [15:0] sum; int due; } tr_t;

   sb_t        sb[$];
   int         grant_log[$];
   tr_t        tq[$];
   int         left[4];
   int         seq[4];
   int         rsp_cnt[4];
   int         n_assert;
   int         n_fail;
   int         cyc;
   logic       rst_v;
   logic [3:0] rsp_rdy;
   logic       tree_rdy;
   logic       hold_results;
   logic       inject_orphan;
   logic       hs_issue;
   logic       hs_pop;
   logic [15:0] hs_x;

   // Lane value for requester r, vector n: all 64 lanes equal, so the sum is value*64 (exponent+6).
   function automatic logic [15:0] val(input int r, input int n);
      logic [9:0] m;
      m = 10'((n * 37 + r * 5) % 1024);
      return {1'b0, 5'(15 + r), m};
   endfunction

   function automatic logic [15:0] sum_of(input int r, input int n);
      logic [9:0] m;
      m = 10'((n * 37 + r * 5) % 1024);
      return {1'b0, 5'(21 + r), m};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Tree stand-in: fixed latency 6, results held while hold_results is set.
   always begin
      @(negedge clk);
      hs_issue = tree_x_valid & tree_ready;
      hs_x     = tree_x[15:0];
      hs_pop   = tree_sum_valid & tree_next_ready & (tq.size() > 0);
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
         tq.delete();
      end else begin
         if (hs_pop) tq.delete(0);
         if (hs_issue) tq.push_back('{hs_x + 16'h1800, cyc + 5});
      end
      if (tq.size() > 0) begin
         tree_sum_valid = (cyc >= tq[0].due) && !hold_results;
         tree_sum       = tq[0].sum;
      end else begin
         tree_sum_valid = inject_orphan;
         tree_sum       = 16'hBEEF;
      end
   end

   task automatic step();
      logic [15:0] e;
      sb_t         s;
      @(posedge clk);
      #1;
      rst        = rst_v;
      tree_ready = tree_rdy;
      rsp_ready  = rsp_rdy;
      for (int r = 0; r < 4; r++) begin
         e = val(r, seq[r]);
         req_valid[r]             = (left[r] > 0);
         req_data[r*1024 +: 1024] = {64{e}};
      end
      @(negedge clk);
      if (!rst) begin
         for (int r = 0; r < 4; r++) begin
            if (req_ready[r]) begin
               sb.push_back('{r, sum_of(r, seq[r])});
               grant_log.push_back(r);
               seq[r]++;
               left[r]--;
            end
         end
         if ((rsp_valid & rsp_ready) != 4'b0) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               s = sb.pop_front();
               chk("rsp_route", 32'(rsp_valid), 32'(4'b1 << s.id));
               chk("rsp_sum", 32'(rsp_sum), 32'(s.sum));
               rsp_cnt[s.id]++;
            end
         end
      end
   endtask

   function automatic bit idle();
      return inflight == 0 && sb.size() == 0 && left[0] == 0 && left[1] == 0 &&
             left[2] == 0 && left[3] == 0;
   endfunction

   task automatic drain(input string tag);
      int n;
      for (n = 0; n < 200; n++) begin
         if (idle()) break;
         step();
      end
      chk({tag, "_drain"}, 32'(n < 200), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n;
      logic [1023:0] exp_vec;
      logic [15:0] exp_s;

      n_assert = 0; n_fail = 0; cyc = 0;
      rst = 1'b1; rst_v = 1'b1;
      req_valid = 4'hF; req_data = '0; tree_ready = 1'b1; rsp_ready = 4'hF;
      tree_sum = '0; tree_sum_valid = 1'b0;
      rsp_rdy = 4'hF; tree_rdy = 1'b1; hold_results = 1'b0; inject_orphan = 1'b0;
      for (int r = 0; r < 4; r++) begin left[r] = 1; seq[r] = 0; rsp_cnt[r] = 0; end

      // Reset state with all requests raised
      step();
      step();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_tree_x_valid", 32'(tree_x_valid), 0);
      chk("rst_tree_next_ready", 32'(tree_next_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_err_orphan", 32'(err_orphan), 0);
      rst_v = 1'b0;
      for (int r = 0; r < 4; r++) left[r] = 0;
      step();

      // Single request, latency 6
      left[0] = 1;
      step();
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      chk("t1_tree_x", 32'(tree_x === {64{16'h3C00}}), 1);
      chk("t1_inflight0", 32'(inflight), 0);
      for (n = 1; n <= 20; n++) begin
         step();
         if (n == 1) chk("t1_inflight1", 32'(inflight), 1);
         if (rsp_valid != 4'b0) break;
      end
      chk("t1_latency", 32'(n), 6);
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_sum", 32'(rsp_sum), 32'h5400);
      step();
      chk("t1_inflight_end", 32'(inflight), 0);

      // Fairness from a fresh reset
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      sb.delete();
      grant_log.delete();
      for (int r = 0; r < 4; r++) begin left[r] = 2; rsp_cnt[r] = 0; end
      for (n = 0; n < 30; n++) begin
         step();
         if (left[0] == 0 && left[1] == 0 && left[2] == 0 && left[3] == 0) break;
      end
      chk("t2_grant_count", 32'(grant_log.size()), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < grant_log.size()) chk($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(i % 4));
      end
      drain("t2");
      for (int r = 0; r < 4; r++) chk($sformatf("t2_rsp_cnt%0d", r), 32'(rsp_cnt[r]), 2);

      // Issue backpressure with a locked grant
      tree_rdy = 1'b0;
      left[2]  = 1;
      exp_vec  = {64{val(2, seq[2])}};
      step();
      chk("t3_valid", 32'(tree_x_valid), 1);
      chk("t3_x0", 32'(tree_x === exp_vec), 1);
      left[0] = 1;
      for (int i = 1; i < 5; i++) begin
         step();
         chk($sformatf("t3_x%0d", i), 32'(tree_x === exp_vec), 1);
         chk($sformatf("t3_ready%0d", i), 32'(req_ready), 0);
      end
      tree_rdy = 1'b1;
      step();
      chk("t3_hs_req2", 32'(req_ready), 32'h4);
      step();
      chk("t3_hs_req0", 32'(req_ready), 32'h1);
      drain("t3");

      // Full tag FIFO
      hold_results = 1'b1;
      left[1] = 17;
      for (n = 0; n < 30; n++) begin
         step();
         if (inflight == 16) break;
      end
      step();
      chk("t4_inflight_full", 32'(inflight), 16);
      chk("t4_valid_full", 32'(tree_x_valid), 0);
      chk("t4_ready_full", 32'(req_ready), 0);
      hold_results = 1'b0;
      step();
      chk("t4_pop_rsp", 32'(rsp_valid), 32'h2);
      chk("t4_valid_on_pop", 32'(tree_x_valid), 0);
      chk("t4_inflight_on_pop", 32'(inflight), 16);
      hold_results = 1'b1;
      step();
      chk("t4_inflight_after_pop", 32'(inflight), 15);
      chk("t4_valid_after_pop", 32'(tree_x_valid), 1);
      chk("t4_ready_after_pop", 32'(req_ready), 32'h2);
      step();
      chk("t4_refull", 32'(inflight), 16);
      hold_results = 1'b0;
      drain("t4");

      // Response backpressure on requester 3
      rsp_rdy = 4'b0111;
      left[3] = 1;
      exp_s   = sum_of(3, seq[3]);
      for (n = 0; n < 20; n++) begin
         step();
         if (rsp_valid != 4'b0) break;
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk($sformatf("t5_rsp_valid%0d", i), 32'(rsp_valid), 32'h8);
         chk($sformatf("t5_next_ready%0d", i), 32'(tree_next_ready), 0);
         chk($sformatf("t5_rsp_sum%0d", i), 32'(rsp_sum), 32'(exp_s));
      end
      rsp_rdy = 4'hF;
      step();
      chk("t5_next_ready_rel", 32'(tree_next_ready), 1);
      chk("t5_rsp_valid_rel", 32'(rsp_valid), 32'h8);
      step();
      chk("t5_inflight_end", 32'(inflight), 0);

      // Orphan result, then reset with work in flight
      inject_orphan = 1'b1;
      step();
      chk("t6_orphan_drain", 32'(tree_next_ready), 1);
      chk("t6_orphan_rsp_valid", 32'(rsp_valid), 0);
      inject_orphan = 1'b0;
      step();
      chk("t6_err_set", 32'(err_orphan), 1);
      step();
      step();
      chk("t6_err_sticky", 32'(err_orphan), 1);
      hold_results = 1'b1;
      left[2] = 5;
      for (n = 0; n < 20; n++) begin
         step();
         if (left[2] == 0) break;
      end
      step();
      chk("t6_inflight5", 32'(inflight), 5);
      rst_v = 1'b1;
      for (int r = 0; r < 4; r++) left[r] = 1;
      step();
      sb.delete();
      chk("t6_rst_inflight", 32'(inflight), 0);
      chk("t6_rst_err", 32'(err_orphan), 0);
      chk("t6_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("t6_rst_req_ready", 32'(req_ready), 0);
      chk("t6_rst_tree_x_valid", 32'(tree_x_valid), 0);
      chk("t6_rst_next_ready", 32'(tree_next_ready), 0);
      hold_results = 1'b0;
      rst_v = 1'b0;
      step();
      chk("t6_first_grant", 32'(req_ready), 32'h1);
      drain("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
